// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, frame-level debounce and key code/flags
// presented as a 32-bit read word for the peripheral decoder.
//
// state | meaning
// COL0  | column 0 driven low
// COL1  | column 1 driven low
// COL2  | column 2 driven low
// COL3  | column 3 driven low; its last cycle ends the frame
module keypad_scanner #(
    parameter int SCAN_CYCLES    = 20000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [3:0]  btn_key_row,
    output logic [3:0]  btn_key_col,
    input  logic        key_clr,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic        key_pending,
    output logic        key_overrun,
    output logic [31:0] key_data
);
    localparam int CW = $clog2(SCAN_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_state_t;

    col_state_t    state, state_next;
    logic [CW-1:0] cyc_cnt;
    logic          col_last, frame_end;
    logic [3:0]    row_low, samp0, samp1, samp2;
    logic [15:0]   frame_vec;
    logic [4:0]    hits;
    logic [3:0]    hit_idx;
    logic          is_multi;
    logic [4:0]    f_class, cand, cand_next, stable;  // {is_key, code}; NONE = 0
    logic [DW-1:0] deb_cnt, cnt_next;
    logic          commit, commit_key, commit_rel;

    assign col_last  = (cyc_cnt == CYC_LAST);
    assign frame_end = col_last && (state == COL3);
    assign row_low   = ~btn_key_row;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) state <= COL0;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (col_last) begin
            case (state)
                COL0:    state_next = COL1;
                COL1:    state_next = COL2;
                COL2:    state_next = COL3;
                default: state_next = COL0;
            endcase
        end
    end

    always_comb begin
        case (state)
            COL0:    btn_key_col = 4'b1110;
            COL1:    btn_key_col = 4'b1101;
            COL2:    btn_key_col = 4'b1011;
            default: btn_key_col = 4'b0111;
        endcase
    end

    // Rows are only trusted on the last cycle of a column period, after settling.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            cyc_cnt <= '0;
            samp0   <= '0;
            samp1   <= '0;
            samp2   <= '0;
        end else begin
            cyc_cnt <= col_last ? '0 : cyc_cnt + 1'b1;
            if (col_last) begin
                case (state)
                    COL0:    samp0 <= row_low;
                    COL1:    samp1 <= row_low;
                    COL2:    samp2 <= row_low;
                    default: ;
                endcase
            end
        end
    end

    // Bit 4*c + r of the frame vector is key k, so a lone hit's index is its code.
    assign frame_vec = {row_low, samp2, samp1, samp0};

    always_comb begin
        hits    = '0;
        hit_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame_vec[i]) begin
                hits    = hits + 5'd1;
                hit_idx = 4'(i);
            end
        end
    end

    assign is_multi = (hits > 5'd1);
    assign f_class  = (hits == 5'd1) ? {1'b1, hit_idx} : 5'd0;

    always_comb begin
        cand_next = cand;
        cnt_next  = deb_cnt;
        if (is_multi) begin
            cnt_next = '0;
        end else if (f_class == cand) begin
            if (deb_cnt != DEB_MAX) cnt_next = deb_cnt + 1'b1;
        end else begin
            cand_next = f_class;
            cnt_next  = DW'(1);
        end
    end

    assign commit     = frame_end && !is_multi && (cnt_next == DEB_MAX) && (cand_next != stable);
    assign commit_key = commit && cand_next[4];
    assign commit_rel = commit && !cand_next[4];

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            cand    <= '0;
            deb_cnt <= '0;
            stable  <= '0;
        end else if (frame_end) begin
            cand    <= cand_next;
            deb_cnt <= cnt_next;
            if (commit) stable <= cand_next;
        end
    end

    // A clear racing a commit loses on pending but still wipes overrun.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            key_code    <= '0;
            key_held    <= 1'b0;
            key_pending <= 1'b0;
            key_overrun <= 1'b0;
        end else begin
            if (commit_key) begin
                key_code <= cand_next[3:0];
                key_held <= 1'b1;
            end else if (commit_rel) begin
                key_held <= 1'b0;
            end
            key_pending <= commit_key || (key_pending && !key_clr);
            key_overrun <= !key_clr && (key_overrun || (commit_key && key_pending));
        end
    end

    assign key_data = {24'b0, key_overrun, key_pending, key_held, 1'b0, key_code};
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix model.
module tb_keypad_scanner;
    localparam int SCAN = 8;
    localparam int DEB  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row, col;
    logic        key_clr = 1'b0;
    logic [3:0]  code;
    logic        held, pend, ovr;
    logic [31:0] data;
    logic [15:0] keys = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [3:0] col;
    } col_vec_t;
    col_vec_t tbl[12];

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_CYCLES(SCAN), .DEBOUNCE_SCANS(DEB)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst_n),
        .btn_key_row (row),
        .btn_key_col (col),
        .key_clr     (key_clr),
        .key_code    (code),
        .key_held    (held),
        .key_pending (pend),
        .key_overrun (ovr),
        .key_data    (data)
    );

    // Pressed key (c,r) pulls row r low while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[4*c+r] && !col[c]) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_flags(input string name, input logic [31:0] exp);
        check({name, " key_data"}, data, exp);
        check({name, " outputs"}, {24'b0, ovr, pend, held, 1'b0, code}, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic goto_cyc(input int n);
        if (cyc < n) tick(n - cyc);
    endtask

    task automatic do_reset(input logic [15:0] k);
        @(negedge clk);
        rst_n   = 1'b0;
        keys    = k;
        key_clr = 1'b0;
        tick(2);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        tbl[0]  = '{0,  4'b1110};
        tbl[1]  = '{7,  4'b1110};
        tbl[2]  = '{8,  4'b1101};
        tbl[3]  = '{15, 4'b1101};
        tbl[4]  = '{16, 4'b1011};
        tbl[5]  = '{23, 4'b1011};
        tbl[6]  = '{24, 4'b0111};
        tbl[7]  = '{31, 4'b0111};
        tbl[8]  = '{32, 4'b1110};
        tbl[9]  = '{40, 4'b1101};
        tbl[10] = '{63, 4'b0111};
        tbl[11] = '{64, 4'b1110};

        // Column drive, no keys
        do_reset(16'h0000);
        for (int i = 0; i < 12; i++) begin
            goto_cyc(tbl[i].cyc);
            check("col_drive", {28'b0, col}, {28'b0, tbl[i].col});
            check("idle_data", data, 32'h0);
        end

        // Single press k=6 held from reset
        do_reset(16'h0040);
        goto_cyc(63);
        check_flags("press_early", 32'h00);
        goto_cyc(64);
        check_flags("press", 32'h66);

        // Clear, then release
        key_clr = 1'b1;
        tick(1);
        key_clr = 1'b0;
        check_flags("clr", 32'h26);
        keys = 16'h0000;
        goto_cyc(127);
        check_flags("release_early", 32'h26);
        goto_cyc(128);
        check_flags("release", 32'h06);

        // Bounce on alternate frames, then steady hold
        do_reset(16'h0000);
        for (int f = 0; f < 6; f++) begin
            goto_cyc(32*f);
            keys = (f % 2 == 0) ? 16'h0040 : 16'h0000;
            goto_cyc(32*f + 31);
            check_flags("bounce", 32'h00);
        end
        goto_cyc(192);
        keys = 16'h0040;
        goto_cyc(255);
        check_flags("hold_early", 32'h00);
        goto_cyc(256);
        check_flags("hold_commit", 32'h66);

        // Release, then press k=15 without clearing
        keys = 16'h0000;
        goto_cyc(319);
        check_flags("rel2_early", 32'h66);
        goto_cyc(320);
        check_flags("rel2", 32'h46);
        keys = 16'h8000;
        goto_cyc(383);
        check_flags("k15_early", 32'h46);
        goto_cyc(384);
        check_flags("overrun", 32'hEF);

        // Clear on the same edge as a new commit
        keys = 16'h0000;
        goto_cyc(448);
        check_flags("rel3", 32'hCF);
        keys = 16'h0040;
        goto_cyc(511);
        check_flags("collide_early", 32'hCF);
        key_clr = 1'b1;
        tick(1);
        key_clr = 1'b0;
        check_flags("collide", 32'h66);

        // MULTI patterns: keys in two columns, then two rows in one column
        keys = 16'h0021;
        goto_cyc(608);
        check_flags("multi_cols", 32'h66);
        keys = 16'h0003;
        goto_cyc(704);
        check_flags("multi_rows", 32'h66);

        // Mid-frame asynchronous reset
        goto_cyc(716);
        check("pre_reset_col", {28'b0, col}, {28'b0, 4'b1101});
        rst_n = 1'b0;
        #1;
        check_flags("async_reset", 32'h00);
        check("async_reset_col", {28'b0, col}, {28'b0, 4'b1110});
        tick(3);
        check("held_reset_col", {28'b0, col}, {28'b0, 4'b1110});
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
